// File: rtl/hcvc_tile_pkg.sv
// Shared definitions for the pixel tile buffer.
//   TILE_PIX / IDX_W : default tile geometry (4x4 tile, 8-bit pixels)
//   tile_state_e     : handshake FSM states (fill / full)
//   tile_pix()       : pixel count of an edge x edge tile
//   idx_width()      : write-index width for a given pixel count
//   slot_lsb()       : LSB of a pixel slot inside the flattened tile vector
package hcvc_tile_pkg;

  localparam int unsigned InSizeDefault   = 4;
  localparam int unsigned BitWidthDefault = 8;
  localparam int unsigned TILE_PIX        = InSizeDefault * InSizeDefault;
  localparam int unsigned IDX_W           = $clog2(TILE_PIX);

  typedef enum logic {
    StFill = 1'b0,
    StFull = 1'b1
  } tile_state_e;

  function automatic int unsigned tile_pix(input int unsigned in_size);
    return in_size * in_size;
  endfunction

  // A 1-pixel tile still needs a 1-bit index to keep vector widths legal.
  function automatic int unsigned idx_width(input int unsigned tp);
    return (tp > 1) ? $clog2(tp) : 1;
  endfunction

  // Pixel 0 sits in the most significant slot, matching avg_pool2d's data_in_flat.
  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned tp,
                                           input int unsigned bw);
    return (tp - 1 - slot) * bw;
  endfunction

endpackage

// File: rtl/tile_bank.sv
// One tile storage bank.
//   clk, rst_n            : clock, asynchronous active-low reset
//   we_i, idx_i, pixel_i  : pixel write port (slot index, pixel data, write enable)
//   set_full_i            : mark the bank as holding a complete tile
//   clr_full_i            : release the bank after the consumer took the tile
//   full_o                : bank holds a complete tile
//   flat_o                : flattened tile contents, pixel 0 in the top slot
module tile_bank
  import hcvc_tile_pkg::*;
#(
  parameter int unsigned TilePix  = TILE_PIX,
  parameter int unsigned BitWidth = BitWidthDefault,
  parameter int unsigned IdxW     = IDX_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic [IdxW-1:0]             idx_i,
  input  logic [BitWidth-1:0]         pixel_i,
  input  logic                        set_full_i,
  input  logic                        clr_full_i,
  output logic                        full_o,
  output logic [TilePix*BitWidth-1:0] flat_o
);

  logic [TilePix*BitWidth-1:0] flat_q;
  logic                        full_q;

  // Slot decode is unrolled so only legal slot indices ever address storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flat_q <= '0;
    end else begin
      for (int unsigned s = 0; s < TilePix; s++) begin
        if (we_i && (idx_i == IdxW'(s))) begin
          flat_q[slot_lsb(s, TilePix, BitWidth) +: BitWidth] <= pixel_i;
        end
      end
    end
  end

  // The top never sets and clears the same bank in one cycle; set wins defensively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (set_full_i) begin
      full_q <= 1'b1;
    end else if (clr_full_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign flat_o = flat_q;

endmodule

// File: rtl/pixel_tile_buffer.sv
// Pixel tile buffer: assembles a raster-order pixel stream into IN_SIZE x IN_SIZE tiles and
// presents each complete tile as a flattened vector for avg_pool2d.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input pixel handshake
//   in_pixel, in_sof     : pixel data, start-of-tile marker
//   out_valid / out_ready: output tile handshake
//   tile_flat            : flattened tile, pixel i at [(TILE_PIX*BIT_WIDTH-1)-i*BIT_WIDTH -: BIT_WIDTH]
//   sof_err              : sticky, in_sof seen on a beat with write index != 0
// Build option: define TILE_BUF_DOUBLE_EN for two ping-pong banks (fill continues while the
// other bank is presented); otherwise a single bank with a fill/full handshake FSM.
module pixel_tile_buffer
  import hcvc_tile_pkg::*;
#(
  parameter int unsigned IN_SIZE   = 4,
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [BIT_WIDTH-1:0]                 in_pixel,
  input  logic                                 in_sof,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [IN_SIZE*IN_SIZE*BIT_WIDTH-1:0] tile_flat,
  output logic                                 sof_err
);

  localparam int unsigned TilePix = tile_pix(IN_SIZE);
  localparam int unsigned IdxW    = idx_width(TilePix);
  localparam int unsigned FlatW   = TilePix * BIT_WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(TilePix - 1);

  logic            accept;
  logic            out_fire;
  logic            sof_restart;
  logic            last_beat;
  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            sof_err_q, sof_err_d;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A misplaced start-of-tile drops the partial tile and restarts at slot 0 with this pixel.
  assign sof_restart = accept & in_sof & (idx_q != '0);
  assign wr_idx      = sof_restart ? '0 : idx_q;
  assign last_beat   = accept & (wr_idx == LastIdx);

  always_comb begin
    idx_d     = idx_q;
    sof_err_d = sof_err_q | sof_restart;
    if (accept) begin
      idx_d = last_beat ? '0 : wr_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      sof_err_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign sof_err = sof_err_q;

`ifdef TILE_BUF_DOUBLE_EN

  // wr_bank_q always points at a free bank unless both are full; rd_bank_q at the oldest tile.
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       bank_full;
  logic [FlatW-1:0] bank_flat [2];

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (last_beat) begin
      wr_bank_d = ~wr_bank_q;
    end
    if (out_fire) begin
      rd_bank_d = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(
      .TilePix (TilePix),
      .BitWidth(BIT_WIDTH),
      .IdxW    (IdxW)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (accept & (wr_bank_q == 1'(b))),
      .idx_i     (wr_idx),
      .pixel_i   (in_pixel),
      .set_full_i(last_beat & (wr_bank_q == 1'(b))),
      .clr_full_i(out_fire & (rd_bank_q == 1'(b))),
      .full_o    (bank_full[b]),
      .flat_o    (bank_flat[b])
    );
  end

  // All three outputs derive from registered bank state only.
  assign in_ready  = ~(&bank_full);
  assign out_valid = bank_full[rd_bank_q];
  assign tile_flat = bank_flat[rd_bank_q];

`else

  tile_state_e state_q;
  logic        bank_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
    end else begin
      case (state_q)
        StFill:  if (last_beat) state_q <= StFull;
        StFull:  if (out_ready) state_q <= StFill;
        default: state_q <= StFill;
      endcase
    end
  end

  tile_bank #(
    .TilePix (TilePix),
    .BitWidth(BIT_WIDTH),
    .IdxW    (IdxW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (accept),
    .idx_i     (wr_idx),
    .pixel_i   (in_pixel),
    .set_full_i(last_beat),
    .clr_full_i(out_fire),
    .full_o    (bank_full),
    .flat_o    (tile_flat)
  );

  // No writes reach the bank while it is full, so tile_flat holds until the consumer takes it.
  assign in_ready  = (state_q == StFill);
  assign out_valid = bank_full;

`endif

endmodule

// File: tb/tb_pixel_tile_buffer.sv
module tb_pixel_tile_buffer;

`ifdef TILE_BUF_DOUBLE_EN
  localparam int Banks = 2;
`else
  localparam int Banks = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_pixel;
  logic         in_sof;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] tile_flat;
  logic         sof_err;

  always #5 clk = ~clk;

  pixel_tile_buffer #(
    .IN_SIZE  (4),
    .BIT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pixel (in_pixel),
    .in_sof   (in_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .tile_flat(tile_flat),
    .sof_err  (sof_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: tiles waiting for the consumer, the tile being assembled, sticky error.
  logic [127:0] exp_q[$];
  logic [7:0]   m_pix [16];
  int           m_idx;
  logic         m_sof_err;
  int           tiles_pushed;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] pack_tile();
    logic [127:0] f = '0;
    for (int i = 0; i < 16; i++) f[127 - i*8 -: 8] = m_pix[i];
    return f;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_idx     = 0;
    m_sof_err = 1'b0;
    for (int i = 0; i < 16; i++) m_pix[i] = 8'h00;
  endtask

  task automatic model_accept(input logic [7:0] p, input logic s);
    if (s && m_idx != 0) begin
      m_sof_err = 1'b1;
      m_idx     = 0;
    end
    m_pix[m_idx] = p;
    m_idx++;
    if (m_idx == 16) begin
      exp_q.push_back(pack_tile());
      m_idx = 0;
      tiles_pushed++;
    end
  endtask

  // Called at a falling edge: drive, check outputs against the model, advance one cycle.
  task automatic step(input logic v, input logic [7:0] p, input logic s, input logic ordy);
    logic acc, fire;
    in_valid  = v;
    in_pixel  = p;
    in_sof    = s;
    out_ready = ordy;
    check_eq("out_valid", out_valid, exp_q.size() > 0);
    check_eq("in_ready", in_ready, exp_q.size() < Banks);
    check_eq("sof_err", sof_err, m_sof_err);
    if (exp_q.size() > 0) check_eq("tile_flat", tile_flat, exp_q[0]);
    acc  = v && (exp_q.size() < Banks);
    fire = ordy && (exp_q.size() > 0);
    @(posedge clk);
    if (fire) void'(exp_q.pop_front());
    if (acc) model_accept(p, s);
    @(negedge clk);
  endtask

  task automatic send_tile(input logic [7:0] base, input logic ordy);
    for (int i = 0; i < 16; i++) step(1'b1, base + 8'(i), (i == 0), ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_tile_flat", tile_flat, 128'h0);
    check_eq("rst_sof_err", sof_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] held;
    logic [127:0] t2_exp;
    int           cyc;
    tiles_pushed = 0;
    in_valid  = 1'b0;
    in_pixel  = 8'h00;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    do_reset();

    // Sixteen pixels 0x01..0x10, consumer ready.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 1), (i == 0), 1'b1);
    t2_exp = 128'h0102030405060708090A0B0C0D0E0F10;
    check_eq("t2_valid", out_valid, 1'b1);
    check_eq("t2_flat", tile_flat, t2_exp);
    drain();

    // Complete tile held against back-pressure for ten cycles.
    send_tile(8'h40, 1'b0);
    held = tile_flat;
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t3_hold", tile_flat, held);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t3_release_valid", out_valid, 1'b0);
    check_eq("t3_release_ready", in_ready, 1'b1);

    // Misplaced start-of-tile after five pixels.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), (i == 0), 1'b0);
    step(1'b1, 8'hA0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    check_eq("t4_sof_err", sof_err, 1'b1);
    check_eq("t4_slot0", tile_flat[127:120], 8'hA0);
    check_eq("t4_slot5", tile_flat[87:80], 8'hB4);
    drain();

    // Random input gaps and consumer stalls over three tiles.
    tiles_pushed = 0;
    cyc = 0;
    while (tiles_pushed < 3 && cyc < 2000) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), (m_idx == 0), 1'($urandom_range(0, 1)));
      cyc++;
    end
    check_eq("t5_tiles", tiles_pushed, 3);
    drain();

`ifdef TILE_BUF_DOUBLE_EN
    // Two back-to-back tiles with the consumer stalled, then drained without a bubble.
    for (int i = 0; i < 32; i++) step(1'b1, 8'(i * 3 + 1), (i % 16 == 0), 1'b0);
    check_eq("t6_full_ready", in_ready, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t6_no_bubble", out_valid, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t6_done", out_valid, 1'b0);
`endif

    // Reset mid-fill discards the partial tile; the next tile starts at slot 0.
    for (int i = 0; i < 7; i++) step(1'b1, 8'hC0 + 8'(i), (i == 0), 1'b0);
    do_reset();
    check_eq("t1_ready", in_ready, 1'b1);
    send_tile(8'h70, 1'b0);
    check_eq("t1_slot0", tile_flat[127:120], 8'h70);
    check_eq("t1_slot15", tile_flat[7:0], 8'h7F);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
